// File: rtl/mprj_cfg_pkg.sv
// mprj_cfg_pkg
// Shared definitions for the pad-control chain configuration loader:
//   - cfg_state_t : sequencer states
//   - DEF_*       : default chain geometry and serial clock divider
//   - DIV_W       : width of the half-period divider counter
//   - xfer_cycles : clock cycles from the start-sample edge to the done cycle
package mprj_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        LOAD_SETUP,
        LOAD,
        DONE
    } cfg_state_t;

    localparam int DEF_NUM_PADS = 38;
    localparam int DEF_CFG_BITS = 13;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_AW       = 6;

    // The divider is sized for the largest legal CLK_DIV (15), independent of AW.
    localparam int DIV_W = 4;

    // Each pad costs a 2-cycle fetch plus two half-periods per bit; the tail
    // adds the load setup and load phases plus the single done cycle.
    function automatic int xfer_cycles(input int num_pads, input int cfg_bits,
                                       input int clk_div);
        return num_pads * (2 + 2 * cfg_bits * clk_div) + 2 * clk_div + 1;
    endfunction

endpackage

// File: rtl/mprj_cfg_clkdiv.sv
// mprj_cfg_clkdiv
// Half-period timer for the serial chain clock. While en is high it counts
// core cycles and raises tick on the last cycle of every CLK_DIV-cycle phase,
// wrapping back to 0 at the same edge. While en is low the count is held at 0
// so every timed phase starts a full half-period.
// Ports:
//   clock  in  core clock
//   reset  in  asynchronous active-high reset
//   en     in  a timed phase is in progress
//   tick   out last cycle of the current phase
module mprj_cfg_clkdiv
    import mprj_cfg_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV   // legal range 1..15
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic tick
);

    logic [DIV_W-1:0] cnt_reg;

    assign tick = en && (cnt_reg == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (!en || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// mprj_io_cfg_loader
// Programs the user-project pad-control chain. On xfer_start (sampled in
// IDLE) it reads one config word per pad from the housekeeping register file,
// highest pad first, shifts each word out MSB-first on a divided serial clock
// and finishes with a single serial_load strobe so the whole chain updates
// at once.
// Ports:
//   clock, reset       core clock, asynchronous active-high reset
//   xfer_start         level request, only looked at in IDLE
//   xfer_busy          high from the cycle after acceptance until the done cycle
//   xfer_done          one-cycle pulse at the end of a transfer
//   cfg_rd_addr        register-file read address (data returns one cycle later)
//   cfg_rd_data        register-file read data
//   serial_clock       chain shift clock, idle low
//   serial_data        chain data, only changes while serial_clock is low
//   serial_load        chain parallel-load strobe, idle low
//   serial_resetn      chain reset, low during reset, high one cycle after release
// Optional build macro MPRJ_CFG_READBACK_EN adds:
//   serial_data_in     chain tail, sampled on the last cycle of each high phase
//   cfg_wr_en          one-cycle write strobe per pad with the old chain word
//   cfg_wr_addr        pad index of the returned word
//   cfg_wr_data        returned word
// CFG_BITS must be at least 2; 2**AW must cover NUM_PADS.
module mprj_io_cfg_loader
    import mprj_cfg_pkg::*;
#(
    parameter int NUM_PADS = DEF_NUM_PADS,
    parameter int CFG_BITS = DEF_CFG_BITS,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int AW       = DEF_AW
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                xfer_start,
    output logic                xfer_busy,
    output logic                xfer_done,
    output logic [AW-1:0]       cfg_rd_addr,
    input  logic [CFG_BITS-1:0] cfg_rd_data,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                serial_resetn
`ifdef MPRJ_CFG_READBACK_EN
    ,
    input  logic                serial_data_in,
    output logic                cfg_wr_en,
    output logic [AW-1:0]       cfg_wr_addr,
    output logic [CFG_BITS-1:0] cfg_wr_data
`endif
);

    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    cfg_state_t            state_reg;
    logic [AW-1:0]         pad_idx_reg;
    logic [BW-1:0]         bit_idx_reg;
    // Bits of the current word still to be sent; the bit being sent already
    // sits in serial_data, so only CFG_BITS-1 bits need holding here.
    logic [CFG_BITS-2:0]   pend_reg;
    logic                  fetch_wait_reg;   // high during the FETCH capture cycle
    logic                  phase_en;
    logic                  phase_end;

    assign phase_en = (state_reg == SHIFT_LO) || (state_reg == SHIFT_HI) ||
                      (state_reg == LOAD_SETUP) || (state_reg == LOAD);

    mprj_cfg_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clock (clock),
        .reset (reset),
        .en    (phase_en),
        .tick  (phase_end)
    );

`ifdef MPRJ_CFG_READBACK_EN
    logic [CFG_BITS-2:0] rb_reg;
    logic [CFG_BITS-1:0] rb_next;

    assign rb_next = {rb_reg, serial_data_in};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            pad_idx_reg    <= '0;
            bit_idx_reg    <= '0;
            pend_reg       <= '0;
            fetch_wait_reg <= 1'b0;
            xfer_busy      <= 1'b0;
            xfer_done      <= 1'b0;
            cfg_rd_addr    <= '0;
            serial_clock   <= 1'b0;
            serial_data    <= 1'b0;
            serial_load    <= 1'b0;
`ifdef MPRJ_CFG_READBACK_EN
            rb_reg         <= '0;
            cfg_wr_en      <= 1'b0;
            cfg_wr_addr    <= '0;
            cfg_wr_data    <= '0;
`endif
        end else begin
`ifdef MPRJ_CFG_READBACK_EN
            cfg_wr_en <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    xfer_done <= 1'b0;
                    if (xfer_start) begin
                        pad_idx_reg    <= AW'(NUM_PADS - 1);
                        cfg_rd_addr    <= AW'(NUM_PADS - 1);
                        fetch_wait_reg <= 1'b0;
                        xfer_busy      <= 1'b1;
                        state_reg      <= FETCH;
                    end
                end

                FETCH: begin
                    // First cycle presents the address; the register file
                    // answers in the second, which is when we capture.
                    if (!fetch_wait_reg) begin
                        fetch_wait_reg <= 1'b1;
                    end else begin
                        fetch_wait_reg <= 1'b0;
                        serial_data    <= cfg_rd_data[CFG_BITS-1];
                        pend_reg       <= cfg_rd_data[CFG_BITS-2:0];
                        bit_idx_reg    <= BW'(CFG_BITS - 1);
                        serial_clock   <= 1'b0;
                        state_reg      <= SHIFT_LO;
                    end
                end

                SHIFT_LO: begin
                    if (phase_end) begin
                        serial_clock <= 1'b1;
                        state_reg    <= SHIFT_HI;
                    end
                end

                SHIFT_HI: begin
                    if (phase_end) begin
                        serial_clock <= 1'b0;
                        pend_reg     <= pend_reg << 1;
`ifdef MPRJ_CFG_READBACK_EN
                        rb_reg <= rb_next[CFG_BITS-2:0];
                        if (bit_idx_reg == '0) begin
                            cfg_wr_en   <= 1'b1;
                            cfg_wr_addr <= pad_idx_reg;
                            cfg_wr_data <= rb_next;
                        end
`endif
                        if (bit_idx_reg != '0) begin
                            bit_idx_reg <= bit_idx_reg - BW'(1);
                            serial_data <= pend_reg[CFG_BITS-2];
                            state_reg   <= SHIFT_LO;
                        end else if (pad_idx_reg != '0) begin
                            pad_idx_reg <= pad_idx_reg - AW'(1);
                            cfg_rd_addr <= pad_idx_reg - AW'(1);
                            state_reg   <= FETCH;
                        end else begin
                            serial_data <= 1'b0;
                            state_reg   <= LOAD_SETUP;
                        end
                    end
                end

                LOAD_SETUP: begin
                    if (phase_end) begin
                        serial_load <= 1'b1;
                        state_reg   <= LOAD;
                    end
                end

                LOAD: begin
                    if (phase_end) begin
                        serial_load <= 1'b0;
                        xfer_busy   <= 1'b0;
                        xfer_done   <= 1'b1;
                        state_reg   <= DONE;
                    end
                end

                DONE: begin
                    xfer_done <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The chain comes out of reset one cycle after the core does.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            serial_resetn <= 1'b0;
        end else begin
            serial_resetn <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// tb_mprj_io_cfg_loader
// Bench for mprj_io_cfg_loader. Two instances: dut0 with the default geometry
// (38 pads x 13 bits, divider 2) and dut1 with a small chain (2 pads x 4 bits,
// divider 1). A registered register-file model feeds each one; a monitor on
// the falling clock edge records the serial stream, load strobes and done
// pulses. Expected streams come from the register-file contents read
// highest pad first, MSB first. Build with MPRJ_CFG_READBACK_EN to also check
// the readback path against a chain model.
module tb_mprj_io_cfg_loader;

    localparam int NP0 = 38;
    localparam int CB0 = 13;
    localparam int CD0 = 2;
    localparam int T0  = NP0 * (2 + 2 * CB0 * CD0) + 2 * CD0 + 1;
    localparam int NP1 = 2;
    localparam int CB1 = 4;
    localparam int CD1 = 1;
    localparam int T1  = NP1 * (2 + 2 * CB1 * CD1) + 2 * CD1 + 1;
    localparam int CHAIN = NP0 * CB0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic start [2] = '{1'b0, 1'b0};
    logic busy [2];
    logic done [2];
    logic sc [2];
    logic sd [2];
    logic ld [2];
    logic rn [2];

    logic [5:0]  addr0;
    logic [0:0]  addr1;
    logic [12:0] rdata0 = '0;
    logic [3:0]  rdata1 = '0;
    logic [12:0] mem0 [64];
    logic [3:0]  mem1 [2];

    always @(posedge clock) begin
        rdata0 <= mem0[addr0];
        rdata1 <= mem1[addr1];
    end

`ifdef MPRJ_CFG_READBACK_EN
    logic        sdi0 = 1'b0;
    logic        wr_en0;
    logic [5:0]  wr_addr0;
    logic [12:0] wr_data0;
    logic        wr_en1;
    logic [0:0]  wr_addr1;
    logic [3:0]  wr_data1;

    function automatic logic [CHAIN-1:0] chain_init();
        logic [CHAIN-1:0] c;
        c = '0;
        for (int p = 0; p < NP0; p++) c[p*CB0 +: CB0] = 13'h100 + 13'(p);
        return c;
    endfunction

    // Chain model: pad p bit b lives at index p*13+b; the bit leaving the
    // far end on each rising serial clock is what the tail returns.
    logic [CHAIN-1:0] chain = chain_init();
    always @(posedge sc[0]) begin
        sdi0  <= chain[CHAIN-1];
        chain <= {chain[CHAIN-2:0], sd[0]};
    end
`endif

    mprj_io_cfg_loader dut0 (
        .clock         (clock),
        .reset         (reset),
        .xfer_start    (start[0]),
        .xfer_busy     (busy[0]),
        .xfer_done     (done[0]),
        .cfg_rd_addr   (addr0),
        .cfg_rd_data   (rdata0),
        .serial_clock  (sc[0]),
        .serial_data   (sd[0]),
        .serial_load   (ld[0]),
        .serial_resetn (rn[0])
`ifdef MPRJ_CFG_READBACK_EN
        ,
        .serial_data_in (sdi0),
        .cfg_wr_en      (wr_en0),
        .cfg_wr_addr    (wr_addr0),
        .cfg_wr_data    (wr_data0)
`endif
    );

    mprj_io_cfg_loader #(
        .NUM_PADS (NP1),
        .CFG_BITS (CB1),
        .CLK_DIV  (CD1),
        .AW       (1)
    ) dut1 (
        .clock         (clock),
        .reset         (reset),
        .xfer_start    (start[1]),
        .xfer_busy     (busy[1]),
        .xfer_done     (done[1]),
        .cfg_rd_addr   (addr1),
        .cfg_rd_data   (rdata1),
        .serial_clock  (sc[1]),
        .serial_data   (sd[1]),
        .serial_load   (ld[1]),
        .serial_resetn (rn[1])
`ifdef MPRJ_CFG_READBACK_EN
        ,
        .serial_data_in (1'b0),
        .cfg_wr_en      (wr_en1),
        .cfg_wr_addr    (wr_addr1),
        .cfg_wr_data    (wr_data1)
`endif
    );

    // ---------------- monitor (counters only ever increase) ----------------
    int          ncap [2]     = '{0, 0};
    int          ld_cyc [2]   = '{0, 0};
    int          ld_pulse [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          stab_err [2] = '{0, 0};
    logic [1023:0] capv [2];
    logic        sc_q [2] = '{1'b0, 1'b0};
    logic        sd_q [2] = '{1'b0, 1'b0};
    logic        ld_q [2] = '{1'b0, 1'b0};
    int          wr_cnt = 0;
    int          wr_err = 0;

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (sc[i] === 1'b1 && sc_q[i] !== 1'b1) begin
                capv[i][ncap[i] % 1024] = sd[i];
                ncap[i]++;
            end
            // Data may only move at an edge that leaves serial_clock low.
            if (sc[i] === 1'b1 && sd[i] !== sd_q[i]) stab_err[i]++;
            if (ld[i] === 1'b1) ld_cyc[i]++;
            if (ld[i] === 1'b1 && ld_q[i] !== 1'b1) ld_pulse[i]++;
            if (done[i] === 1'b1) done_cnt[i]++;
            sc_q[i] = sc[i];
            sd_q[i] = sd[i];
            ld_q[i] = ld[i];
        end
`ifdef MPRJ_CFG_READBACK_EN
        if (wr_en0 === 1'b1) begin
            if (wr_addr0 !== 6'(NP0 - 1 - wr_cnt) ||
                wr_data0 !== 13'h100 + 13'(NP0 - 1 - wr_cnt)) wr_err++;
            wr_cnt++;
        end
`endif
    end

    // ---------------- checking helpers ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    int base_cap [2];
    int base_ldc [2];
    int base_ldp [2];
    int base_done [2];
    int base_stab [2];

    task automatic snap(input int sel);
        base_cap[sel]  = ncap[sel];
        base_ldc[sel]  = ld_cyc[sel];
        base_ldp[sel]  = ld_pulse[sel];
        base_done[sel] = done_cnt[sel];
        base_stab[sel] = stab_err[sel];
    endtask

    function automatic logic cap_bit(input int sel, input int k);
        return capv[sel][(base_cap[sel] + k) % 1024];
    endfunction

    // One transfer: start is raised for a single sample, n counts cycles with
    // the cycle after the start-sample edge as 1, and stops on done or limit.
    task automatic run_xfer(input int sel, input int limit, input bit poke,
                            output int n, output logic busy_first);
        @(negedge clock);
        snap(sel);
        start[sel] = 1'b1;
        @(negedge clock);
        n = 1;
        start[sel] = 1'b0;
        busy_first = busy[sel];
        while (done[sel] !== 1'b1 && n < limit) begin
            @(negedge clock);
            n++;
            if (poke) start[sel] = (n % 500 == 0);
        end
        start[sel] = 1'b0;
    endtask

    task automatic check_default(input string name, input int n, input logic b1);
        int bad;
        logic [12:0] w;
        bad = 0;
        for (int k = 0; k < NP0; k++) begin
            w = '0;
            for (int j = 0; j < CB0; j++) w = {w[11:0], cap_bit(0, k * CB0 + j)};
            if (w !== mem0[NP0 - 1 - k]) bad++;
        end
        $display("xfer %s: cycles=%0d bits=%0d load_cycles=%0d bad_words=%0d",
                 name, n, ncap[0] - base_cap[0], ld_cyc[0] - base_ldc[0], bad);
        chk({name, " done cycle"}, n, T0);
        chk({name, " busy first cycle"}, int'(b1), 1);
        chk({name, " busy at done"}, int'(busy[0]), 0);
        chk({name, " bit count"}, ncap[0] - base_cap[0], CHAIN);
        chk({name, " load pulses"}, ld_pulse[0] - base_ldp[0], 1);
        chk({name, " load cycles"}, ld_cyc[0] - base_ldc[0], CD0);
        chk({name, " data stable"}, stab_err[0] - base_stab[0], 0);
        chk({name, " word errors"}, bad, 0);
        @(negedge clock);
        chk({name, " done one cycle"}, int'(done[0]), 0);
    endtask

    task automatic small_xfer(input string name, input logic [3:0] d0,
                              input logic [3:0] d1, input logic [7:0] exp_s,
                              input int exp_t);
        int n;
        logic b1;
        logic [7:0] got;
        mem1[0] = d0;
        mem1[1] = d1;
        run_xfer(1, T1 + 20, 1'b0, n, b1);
        got = '0;
        for (int k = 0; k < 8; k++) got = {got[6:0], cap_bit(1, k)};
        $display("xfer %s: d0=%h d1=%h stream=%h cycles=%0d", name, d0, d1, got, n);
        chk({name, " stream"}, int'(got), int'(exp_s));
        chk({name, " done cycle"}, n, exp_t);
        chk({name, " busy first cycle"}, int'(b1), 1);
        chk({name, " bit count"}, ncap[1] - base_cap[1], 8);
        chk({name, " load cycles"}, ld_cyc[1] - base_ldc[1], CD1);
        chk({name, " data stable"}, stab_err[1] - base_stab[1], 0);
    endtask

    typedef struct {
        logic [3:0] d0;
        logic [3:0] d1;
        logic [7:0] stream;
        int         t;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin
        vec_t vt [4];
        int n, n1, n2, n3;
        logic b1;
        logic [12:0] w;
        logic [3:0] r0, r1;

        vt[0] = '{d0: 4'hA, d1: 4'h5, stream: 8'h5A, t: 23};
        vt[1] = '{d0: 4'hF, d1: 4'h0, stream: 8'h0F, t: 23};
        vt[2] = '{d0: 4'h3, d1: 4'hC, stream: 8'hC3, t: 23};
        vt[3] = '{d0: 4'h6, d1: 4'h9, stream: 8'h96, t: 23};

        for (int a = 0; a < 64; a++) mem0[a] = 13'(a) ^ 13'h1A5;
        mem1[0] = '0;
        mem1[1] = '0;

        // Reset values.
        repeat (3) @(negedge clock);
        chk("reset busy", int'(busy[0]), 0);
        chk("reset done", int'(done[0]), 0);
        chk("reset serial_clock", int'(sc[0]), 0);
        chk("reset serial_data", int'(sd[0]), 0);
        chk("reset serial_load", int'(ld[0]), 0);
        chk("reset rd_addr", int'(addr0), 0);
        chk("reset serial_resetn", int'(rn[0]), 0);
        reset = 1'b0;
        #1;
        chk("resetn low before edge", int'(rn[0]), 0);
        @(posedge clock);
        #1;
        chk("resetn high after edge", int'(rn[0]), 1);
        chk("small resetn high", int'(rn[1]), 1);

        // Default geometry, addr ^ 0x1A5 pattern.
        run_xfer(0, T0 + 50, 1'b0, n, b1);
        w = '0;
        for (int j = 0; j < CB0; j++) w = {w[11:0], cap_bit(0, j)};
        chk("first word", int'(w), int'(13'd37 ^ 13'h1A5));
        check_default("pattern", n, b1);
`ifdef MPRJ_CFG_READBACK_EN
        chk("readback writes", wr_cnt, NP0);
        chk("readback errors", wr_err, 0);
`endif

        // Small geometry, table then random words.
        for (int i = 0; i < 4; i++) small_xfer($sformatf("vec%0d", i), vt[i].d0, vt[i].d1,
                                               vt[i].stream, vt[i].t);
        for (int i = 0; i < 4; i++) begin
            r0 = 4'($urandom);
            r1 = 4'($urandom);
            small_xfer($sformatf("rnd%0d", i), r0, r1, {r1, r0}, T1);
        end

        // Default geometry with random register-file contents.
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < 64; a++) mem0[a] = 13'($urandom);
            run_xfer(0, T0 + 50, 1'b0, n, b1);
            check_default($sformatf("random%0d", r), n, b1);
        end

        // Start pulses while busy must not create extra transfers.
        run_xfer(0, T0 + 50, 1'b1, n, b1);
        check_default("pokes", n, b1);
        repeat (20) @(negedge clock);
        chk("pokes done count", done_cnt[0] - base_done[0], 1);
        chk("pokes idle busy", int'(busy[0]), 0);

        // Start held high: the next transfer is accepted in the cycle after done.
        @(negedge clock);
        snap(0);
        start[0] = 1'b1;
        n = 0; n1 = 0; n2 = 0; n3 = 0;
        while (n3 == 0 && n < 3 * T0) begin
            @(negedge clock);
            n++;
            if (n1 == 0 && done[0] === 1'b1) n1 = n;
            else if (n1 != 0 && n2 == 0 && busy[0] === 1'b1) begin
                n2 = n;
                start[0] = 1'b0;
            end else if (n2 != 0 && done[0] === 1'b1) n3 = n;
        end
        start[0] = 1'b0;
        $display("xfer held: first_done=%0d second_busy=%0d second_done=%0d", n1, n2, n3);
        chk("held first done", n1, T0);
        chk("held restart", n2, T0 + 2);
        chk("held second done", n3, 2 * T0 + 1);
        chk("held load pulses", ld_pulse[0] - base_ldp[0], 2);
        chk("held bit count", ncap[0] - base_cap[0], 2 * CHAIN);

        // Reset in the middle of a transfer, while serial_clock is high.
        @(negedge clock);
        snap(0);
        start[0] = 1'b1;
        n = 0;
        while ((n < 700 || sc[0] !== 1'b1) && n < T0) begin
            @(negedge clock);
            n++;
            start[0] = 1'b0;
        end
        chk("pre-reset clock high", int'(sc[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        $display("xfer reset at cycle %0d: sc=%b busy=%b resetn=%b", n, sc[0], busy[0], rn[0]);
        chk("midreset serial_clock", int'(sc[0]), 0);
        chk("midreset busy", int'(busy[0]), 0);
        chk("midreset resetn", int'(rn[0]), 0);
        chk("midreset serial_data", int'(sd[0]), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midreset resetn held", int'(rn[0]), 0);
        @(posedge clock);
        #1;
        chk("midreset resetn release", int'(rn[0]), 1);
        chk("midreset no load", ld_pulse[0] - base_ldp[0], 0);
        run_xfer(0, T0 + 50, 1'b0, n, b1);
        check_default("after reset", n, b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mprj_io_cfg_loader.md
Name: mprj_io_cfg_loader

Overview:
- Serial configuration engine that programs the per-pad control chain feeding the user-project pad ring. That chain drives mprj_io_oeb, dm, inp_dis, vtrip_sel and the other pad-control signals.
- On a start request it reads one config word per pad from the housekeeping register file. It shifts every word out MSB-first on a divided serial clock, then pulses a load strobe so the whole chain updates in a single step.
- Sits between the housekeeping register file and the pad-control chain, directly upstream of the pad frame.

Parameters:
- NUM_PADS, 38, number of user pads in the chain (equals `MPRJ_IO_PADS).
- CFG_BITS, 13, config bits per pad.
- CLK_DIV, 2, core cycles per serial_clock half-period; legal range 1 to 15.
- AW, 6, width of the config address; 2**AW must be >= NUM_PADS.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- xfer_start  in  1  level; sampled only in IDLE.
- xfer_busy  out  1  high from the cycle after start is accepted until done.
- xfer_done  out  1  one-cycle pulse at the end of a transfer.
- cfg_rd_addr  out  AW  register-file read address; data returns one cycle later.
- cfg_rd_data  in  CFG_BITS  register-file read data.
- serial_clock  out  1  chain shift clock; idle low.
- serial_data  out  1  chain data; changes only while serial_clock is low.
- serial_load  out  1  chain parallel-load strobe; idle low.
- serial_resetn  out  1  chain reset; registered, low while reset is asserted, high one cycle after reset is released.

Behaviour:
- Reset values:
  - Outputs: busy=0, done=0, serial_clock=0, serial_data=0, serial_load=0, cfg_rd_addr=0, serial_resetn=0.
  - State: state=IDLE; pad counter, bit counter and divider counter all 0.
- All outputs are registered.
- State machine:
  - IDLE: if xfer_start=1, set pad_idx=NUM_PADS-1, drive cfg_rd_addr=pad_idx, go to FETCH.
  - FETCH (2 cycles): cycle 1 is the address phase. Cycle 2 captures cfg_rd_data into the shift register and sets bit_idx=CFG_BITS-1.
  - SHIFT_LO (CLK_DIV cycles): serial_clock=0, serial_data=shreg[CFG_BITS-1].
  - SHIFT_HI (CLK_DIV cycles): serial_clock=1, data held. On exit, shift left by 1.
    - If bit_idx>0: decrement bit_idx and go to SHIFT_LO.
    - Else if pad_idx>0: decrement pad_idx and go to FETCH.
    - Else: go to LOAD_SETUP.
  - LOAD_SETUP (CLK_DIV cycles): serial_clock=0, serial_data=0.
  - LOAD (CLK_DIV cycles): serial_load=1.
  - DONE (1 cycle): xfer_done=1, busy=0, back to IDLE.
- Order: pad NUM_PADS-1 is sent first; within each word, bit CFG_BITS-1 is sent first.
- Total cycles from the start-sample edge to the done cycle: T = NUM_PADS*(2+2*CFG_BITS*CLK_DIV) + 2*CLK_DIV + 1. With defaults T=2057.
- xfer_start while busy is ignored; no queuing. If start is held high through DONE, a new transfer begins the cycle after DONE.
- Reset mid-transfer: immediate return to reset values; serial_load is never asserted and the partial chain contents are undefined.
- Divider counter is AW-independent and 4 bits wide; it wraps to 0 at CLK_DIV-1.

Optional Feature:
- Macro: MPRJ_CFG_READBACK_EN.
- When defined:
  - Adds ports: serial_data_in (in, 1, chain tail), cfg_wr_en (out, 1), cfg_wr_addr (out, AW), cfg_wr_data (out, CFG_BITS).
  - serial_data_in is sampled on the last cycle of each SHIFT_HI and shifted into a readback register.
  - After the last bit of each word, assert cfg_wr_en for one cycle with cfg_wr_addr=pad_idx and cfg_wr_data=the old chain word. Because the chain tail holds pad NUM_PADS-1, the returned word order matches the send order.
  - cfg_wr_en resets to 0.
- When undefined: these ports and all readback logic are absent.

Decomposition:
- Package mprj_cfg_pkg: state enum (IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD_SETUP, LOAD, DONE), default NUM_PADS/CFG_BITS constants, and a function computing transfer cycles.
- One sub-module, mprj_cfg_clkdiv: half-period counter producing a phase-end tick.

Test Plan:
- Defaults; rd_data=addr XOR 13'h1A5; pulse start -> capture 494 bits on rising serial_clock. The first 13 bits equal 37^13'h1A5 MSB-first; one serial_load pulse of 2 cycles; done at cycle 2057.
- CLK_DIV=1, NUM_PADS=2, CFG_BITS=4, rd_data=4'hA,4'h5 -> serial stream 0101 1010 (pad1 then pad0); done at T=2*(2+8)+2+1=23.
- Start held high for 3000 cycles -> second transfer begins exactly 1 cycle after the first done; start pulses during busy cause no extra transfer.
- Assert reset at cycle 700 -> same-edge serial_clock=0, busy=0, serial_resetn=0; no serial_load seen; a later start completes a normal transfer.
- serial_data stability: assert serial_data never changes while serial_clock=1 across a full transfer.
- MPRJ_CFG_READBACK_EN with a 494-bit chain model preloaded with pad p = 13'h100+p -> 38 cfg_wr_en pulses; addresses 37..0 carry 13'h100+addr.
